// File: rtl/palette_ctrl.sv
// rtl/palette_ctrl.sv - palette RAM sequencer: 2-entry CPU write FIFO, pixel lookup pipeline, collision forwarding
// Optional PALETTE_WRITE_IN_BLANK_EN: hold posted writes until the video is in blanking.
module palette_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_wr_valid,
  output logic       cpu_wr_ready,
  input  logic [3:0] cpu_wr_addr,
  input  logic [7:0] cpu_wr_data,
  input  logic       pix_valid,
  input  logic [3:0] pix_index,
  input  logic       pix_blank,
  output logic       pal_we,
  output logic [3:0] pal_addr_wr,
  output logic [7:0] pal_data_wr,
  output logic       pal_en_rd,
  output logic [3:0] pal_addr_rd,
  input  logic [7:0] pal_data_rd,
  output logic       color_valid,
  output logic [7:0] color_out,
  output logic       color_blank
);

  logic [3:0] fifo_addr [2];
  logic [7:0] fifo_data [2];
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       drain_ok;
  logic       push;
  logic       pop;

  logic       s1_valid;
  logic       s1_blank;
  logic       s1_byp;
  logic [7:0] s1_bdata;

`ifdef PALETTE_WRITE_IN_BLANK_EN
  assign drain_ok = pix_blank;
`else
  assign drain_ok = 1'b1;
`endif

  assign cpu_wr_ready = (count != 2'd2) && reset_n;
  assign push         = cpu_wr_valid && cpu_wr_ready;
  // Gated by reset_n so a half-drained FIFO cannot write the RAM while reset is held.
  assign pal_we       = (count != 2'd0) && drain_ok && reset_n;
  assign pop          = pal_we;
  assign pal_addr_wr  = fifo_addr[head];
  assign pal_data_wr  = fifo_data[head];
  assign pal_en_rd    = pix_valid;
  assign pal_addr_rd  = pix_index;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= cpu_wr_addr;
      fifo_data[tail] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Stage 1: note whether the RAM is being written at this same address this cycle,
  // since the RAM read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
    end
    if (pix_valid) begin
      s1_blank <= pix_blank;
      s1_byp   <= pal_we && (pal_addr_wr == pix_index);
      s1_bdata <= pal_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      color_valid <= 1'b0;
      color_blank <= 1'b0;
      color_out   <= 8'h00;
    end else begin
      color_valid <= s1_valid;
      color_blank <= s1_blank;
      if (s1_valid) begin
        color_out <= s1_blank ? 8'h00 : (s1_byp ? s1_bdata : pal_data_rd);
      end
    end
  end

endmodule

// File: tb/tb_palette_ctrl.sv
// tb/tb_palette_ctrl.sv - self-checking bench for palette_ctrl against a queue-based palette model
// Honours PALETTE_WRITE_IN_BLANK_EN when defined for the build.
module tb_palette_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_wr_valid;
  logic       cpu_wr_ready;
  logic [3:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic       pix_valid;
  logic [3:0] pix_index;
  logic       pix_blank;
  logic       pal_we;
  logic [3:0] pal_addr_wr;
  logic [7:0] pal_data_wr;
  logic       pal_en_rd;
  logic [3:0] pal_addr_rd;
  logic [7:0] pal_data_rd;
  logic       color_valid;
  logic [7:0] color_out;
  logic       color_blank;

  palette_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .pix_valid(pix_valid), .pix_index(pix_index), .pix_blank(pix_blank),
    .pal_we(pal_we), .pal_addr_wr(pal_addr_wr), .pal_data_wr(pal_data_wr),
    .pal_en_rd(pal_en_rd), .pal_addr_rd(pal_addr_rd), .pal_data_rd(pal_data_rd),
    .color_valid(color_valid), .color_out(color_out), .color_blank(color_blank)
  );

  always #5 clk = ~clk;

  // Palette RAM: 1-cycle read latency, read returns the value before a same-edge write.
  logic [7:0] ram [16] = '{default: 8'h00};
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (pal_en_rd) rd_q <= ram[pal_addr_rd];
    if (pal_we) ram[pal_addr_wr] <= pal_data_wr;
  end
  assign pal_data_rd = rd_q;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        q[$];
  logic [7:0] model_pal [16] = '{default: 8'h00};
  bit         e1_v, e1_b, e2_v, e2_b;
  logic [7:0] e1_c, e2_c;
  logic [7:0] exp_color = 8'h00;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance the model.
  task automatic step();
    bit  m_ready, m_we, drain_ok;
    wr_t w;
    @(negedge clk);
`ifdef PALETTE_WRITE_IN_BLANK_EN
    drain_ok = pix_blank;
`else
    drain_ok = 1'b1;
`endif
    m_ready = reset_n && (q.size() != 2);
    m_we    = reset_n && (q.size() != 0) && drain_ok;
    chk("cpu_wr_ready", 8'(cpu_wr_ready), 8'(m_ready));
    chk("pal_we", 8'(pal_we), 8'(m_we));
    if (m_we) begin
      chk("pal_addr_wr", 8'(pal_addr_wr), 8'(q[0].a));
      chk("pal_data_wr", pal_data_wr, q[0].d);
    end
    chk("color_valid", 8'(color_valid), 8'(e2_v));
    chk("color_out", color_out, exp_color);
    if (e2_v) chk("color_blank", 8'(color_blank), 8'(e2_b));
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      e1_v = 0; e2_v = 0; exp_color = 8'h00;
    end else begin
      if (m_we) begin
        w = q.pop_front();
        model_pal[w.a] = w.d;
      end
      e2_v = e1_v; e2_b = e1_b; e2_c = e1_c;
      e1_v = pix_valid; e1_b = pix_blank;
      e1_c = pix_blank ? 8'h00 : model_pal[pix_index];
      if (e2_v) exp_color = e2_c;
      if (cpu_wr_valid && m_ready) begin
        w.a = cpu_wr_addr;
        w.d = cpu_wr_data;
        q.push_back(w);
      end
    end
    #1;
  endtask

  task automatic idle();
    cpu_wr_valid = 0;
    pix_valid    = 0;
    pix_blank    = 1;
  endtask

  initial begin
    reset_n = 0; cpu_wr_valid = 1; cpu_wr_addr = 4'h1; cpu_wr_data = 8'hFF;
    pix_valid = 1; pix_index = 4'h2; pix_blank = 0;
    @(posedge clk); #1;
    repeat (3) step();
    chk("reset_color_out", color_out, 8'h00);
    chk("reset_color_valid", 8'(color_valid), 8'h00);
    chk("reset_ready", 8'(cpu_wr_ready), 8'h00);
    chk("reset_pal_we", 8'(pal_we), 8'h00);
    idle();
    reset_n = 1;
    #1;
    chk("ready_after_release", 8'(cpu_wr_ready), 8'h01);
    step();

    // Back-to-back writes 0..3 -> 10..13
    for (int i = 0; i < 4; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = 4'(i); cpu_wr_data = 8'h10 + 8'(i);
      #1;
      chk("b2b_ready", 8'(cpu_wr_ready), 8'h01);
      step();
    end
    idle();
    repeat (2) step();

    // Write 3 = A5, drain, then look it up
    cpu_wr_valid = 1; cpu_wr_addr = 4'h3; cpu_wr_data = 8'hA5;
    step();
    idle();
    step();
    pix_valid = 1; pix_index = 4'h3; pix_blank = 0;
    step();
    idle();
    step();
    chk("read_a5", color_out, 8'hA5);
    chk("read_a5_valid", 8'(color_valid), 8'h01);

    // Blanking forces black
    pix_valid = 1; pix_index = 4'h3; pix_blank = 1;
    step();
    idle();
    step();
    chk("blank_color", color_out, 8'h00);
    chk("blank_flag", 8'(color_blank), 8'h01);

`ifndef PALETTE_WRITE_IN_BLANK_EN
    // Collision: write 5 = 7E drains in the same cycle as the lookup of 5
    cpu_wr_valid = 1; cpu_wr_addr = 4'h5; cpu_wr_data = 8'h7E;
    step();
    cpu_wr_valid = 0;
    pix_valid = 1; pix_index = 4'h5; pix_blank = 0;
    step();
    idle();
    step();
    chk("collision", color_out, 8'h7E);
`else
    // Writes wait in the FIFO during active video
    pix_blank = 0; pix_valid = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = 4'h8 + 4'(i); cpu_wr_data = 8'h21 + 8'(i);
      step();
    end
    cpu_wr_addr = 4'hA; cpu_wr_data = 8'h23;
    #1;
    chk("blocked_ready", 8'(cpu_wr_ready), 8'h00);
    chk("blocked_we", 8'(pal_we), 8'h00);
    step();
    pix_blank = 1;
    repeat (2) step();
    cpu_wr_valid = 0;
    repeat (2) step();
    chk("drained_8", ram[8], 8'h21);
    chk("drained_10", ram[10], 8'h23);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      reset_n      = ($urandom_range(0, 63) != 0);
      cpu_wr_valid = $urandom_range(0, 1) == 1;
      cpu_wr_addr  = 4'($urandom_range(0, 15));
      cpu_wr_data  = 8'($urandom);
      pix_valid    = $urandom_range(0, 3) != 0;
      pix_index    = 4'($urandom_range(0, 15));
      pix_blank    = $urandom_range(0, 3) == 0;
      step();
    end
    reset_n = 1;
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/palette_ctrl.md
# palette_ctrl

Sequencing controller in front of the 16x8 palette RAM. Accepts CPU palette writes through a valid/ready port into a 2-entry posting FIFO, drains them into the RAM write port, and drives the RAM read port from the video pixel stream. Forwards same-cycle write data on address collisions and registers the final 8-bit colour for the video output stage, forcing black during blanking.

## Interface
- No parameters; depth (2), address width (4) and data width (8) are fixed.
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  FIFO can accept; transfer when valid && ready
- cpu_wr_addr  in  4  palette entry to write
- cpu_wr_data  in  8  colour value to write
- pix_valid  in  1  pixel strobe; one palette lookup per asserted cycle
- pix_index  in  4  palette index for this pixel
- pix_blank  in  1  pixel lies in blanking interval
- pal_we  out  1  RAM write enable
- pal_addr_wr  out  4  RAM write address
- pal_data_wr  out  8  RAM write data
- pal_en_rd  out  1  RAM read enable
- pal_addr_rd  out  4  RAM read address
- pal_data_rd  in  8  RAM read data, valid the cycle after pal_en_rd
- color_valid  out  1  color_out carries a pixel
- color_out  out  8  final pixel colour
- color_blank  out  1  blank flag aligned with color_out

## Operation
- Write FIFO: 2 entries, head/tail pointers plus count (0..2). cpu_wr_ready = (count != 2) && reset_n. Push on valid && ready.
- Drain: drain_ok = 1 (see Configuration). pal_we = (count != 0) && drain_ok; pal_addr_wr/pal_data_wr = head entry (combinational from FIFO registers). Pop on pal_we.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap 1->0.
- Writes reach the RAM in CPU order; no entry is dropped or merged.
- Read: pal_en_rd = pix_valid; pal_addr_rd = pix_index (combinational).
- Stage 1 (registered on pix_valid cycle): s1_valid, s1_blank, s1_byp = pal_we && (pal_addr_wr == pix_index), s1_bdata = pal_data_wr.
- Stage 2 (registered): color_valid <= s1_valid; color_blank <= s1_blank; color_out <= s1_blank ? 8'h00 : (s1_byp ? s1_bdata : pal_data_rd). When s1_valid = 0, color_out holds its previous value.
- Entries still in the FIFO are not forwarded; a read of an address with only a pending write returns the old RAM value.
- Reset (any cycle, including mid-drain): count, pointers, s1_valid, color_valid, color_blank -> 0; color_out -> 8'h00; FIFO contents discarded; no pal_we during reset.

## Timing
- Outputs during/after reset: cpu_wr_ready 0 while reset_n = 0, 1 the first cycle after release; pal_we 0; color_valid 0; color_out 8'h00; color_blank 0.
- Write latency: push at edge N -> pal_we high in cycle N+1 (if drain_ok) -> RAM updated at edge N+1.
- Throughput: one CPU write per cycle sustained while draining; with drain blocked, third write stalls (ready = 0) until a pop.
- Read latency: pix_valid in cycle N -> color_valid/color_out in cycle N+2; one pixel per cycle, fully pipelined.
- Collision: pal_we to address A in cycle N with pix_valid, pix_index = A in cycle N -> color_out in N+2 equals the newly written data.

## Configuration
- PALETTE_WRITE_IN_BLANK_EN defined: drain_ok = pix_blank; writes only land during blanking, so visible pixels never change colour mid-line. Writes accepted during active video wait in the FIFO; ready drops once 2 are pending.
- Undefined: drain_ok = 1; writes drain immediately regardless of video timing.

## Test plan
- Reset: hold reset_n = 0 with cpu_wr_valid = 1, pix_valid = 1 -> pal_we = 0, color_valid = 0, color_out = 8'h00, cpu_wr_ready = 0; release -> ready = 1 next cycle.
- Write then read: write addr 3 = 8'hA5; after drain, pix_index = 3 with pix_valid -> color_out = 8'hA5 exactly 2 cycles later, color_valid = 1.
- Back-to-back: push 4 writes on consecutive cycles (addr 0..3, data 8'h10..8'h13) -> pal_we 4 consecutive cycles in order, ready never drops (macro undefined).
- Collision: RAM[5] = 8'h00, write 5 = 8'h7E draining in the same cycle pix_index = 5 -> color_out = 8'h7E, not 8'h00.
- Blanking: pix_blank = 1, pix_index = 3 (RAM 8'hA5) -> color_out = 8'h00, color_blank = 1.
- Macro defined: pix_blank = 0, push 3 writes -> ready = 0 after 2 pushes, no pal_we; raise pix_blank -> 2 writes drain on consecutive cycles, third accepted then drained, order preserved.
